// File: rtl/reg_bus_ctrl_if.sv
// Request/response handshake between instruction decode and the register-bus sequencer.
interface reg_bus_ctrl_if;
  logic       req_i;
  logic [1:0] op_i;
  logic [2:0] src_i;
  logic [2:0] dst_i;
  logic [7:0] imm_i;
  logic [7:0] rd_data_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  modport master (
    output req_i, op_i, src_i, dst_i, imm_i,
    input  rd_data_o, busy_o, done_o, err_o
  );

  modport slave (
    input  req_i, op_i, src_i, dst_i, imm_i,
    output rd_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/reg_bus_ctrl.sv
// Sequences one bus phase per cycle between the eight working-register slots on the
// shared internal data bus: MOV, MVI, RDR and the DE/HL exchange.
module reg_bus_ctrl (
  input  logic              clk50M_i,
  input  logic              rst_ni,
  reg_bus_ctrl_if.slave     bus_if,
  output logic [7:0]        latch_rd_o,
  output logic [7:0]        latch_wr_o,
  inout  wire  [7:0]        bus_io
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_XCH = 2'b10;
  localparam logic [1:0] OP_RDR = 2'b11;

  localparam logic [2:0] SL_D = 3'd2;
  localparam logic [2:0] SL_E = 3'd3;
  localparam logic [2:0] SL_H = 3'd4;
  localparam logic [2:0] SL_L = 3'd5;
  localparam logic [2:0] SL_M = 3'd6;

  typedef enum logic [3:0] {
    IDLE, RD, WR, X0, X1, X2, X3, X4, X5, X6, X7, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] t0_q, t0_d;
  logic [7:0] t1_q, t1_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       err_q, err_d;

  logic       rd_en, wr_en;
  logic [2:0] slot;
  logic [7:0] wbyte;

  function automatic logic illegal_req(input logic [1:0] op, input logic [2:0] src,
                                       input logic [2:0] dst);
    case (op)
      OP_MOV:  return (src == SL_M) || (dst == SL_M);
      OP_MVI:  return dst == SL_M;
      OP_RDR:  return src == SL_M;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] s);
    return 8'h01 << s;
  endfunction

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= OP_MOV;
      src_q     <= 3'd0;
      dst_q     <= 3'd0;
      imm_q     <= 8'h00;
      t0_q      <= 8'h00;
      t1_q      <= 8'h00;
      rd_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    slot      = 3'd0;
    wbyte     = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus_if.req_i) begin
          if (illegal_req(bus_if.op_i, bus_if.src_i, bus_if.dst_i)) begin
            err_d = 1'b1;
          end else begin
            op_d  = bus_if.op_i;
            src_d = bus_if.src_i;
            dst_d = bus_if.dst_i;
            imm_d = bus_if.imm_i;
            case (bus_if.op_i)
              OP_MVI:  state_d = WR;
              OP_XCH:  state_d = X0;
              default: state_d = RD;
            endcase
          end
        end
      end
      RD: begin
        rd_en = 1'b1;
        slot  = src_q;
        if (op_q == OP_MOV) begin
          t0_d    = bus_io;
          state_d = WR;
        end else begin
          rd_data_d = bus_io;
          state_d   = DONE;
        end
      end
      WR: begin
        wr_en   = 1'b1;
        slot    = dst_q;
        wbyte   = (op_q == OP_MVI) ? imm_q : t0_q;
        state_d = DONE;
      end
      // Exchange: park D,H in T0/T1, cross-write, then repeat for E,L.
      X0: begin rd_en = 1'b1; slot = SL_D; t0_d = bus_io; state_d = X1; end
      X1: begin rd_en = 1'b1; slot = SL_H; t1_d = bus_io; state_d = X2; end
      X2: begin wr_en = 1'b1; slot = SL_H; wbyte = t0_q;  state_d = X3; end
      X3: begin wr_en = 1'b1; slot = SL_D; wbyte = t1_q;  state_d = X4; end
      X4: begin rd_en = 1'b1; slot = SL_E; t0_d = bus_io; state_d = X5; end
      X5: begin rd_en = 1'b1; slot = SL_L; t1_d = bus_io; state_d = X6; end
      X6: begin wr_en = 1'b1; slot = SL_L; wbyte = t0_q;  state_d = X7; end
      X7: begin wr_en = 1'b1; slot = SL_E; wbyte = t1_q;  state_d = DONE; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_ni keeps the strobes and bus release purely combinational from reset.
  assign latch_rd_o = (rd_en && rst_ni) ? onehot(slot) : 8'h00;
  assign latch_wr_o = (wr_en && rst_ni) ? onehot(slot) : 8'h00;
  assign bus_io     = (wr_en && rst_ni) ? wbyte : 8'hzz;

  assign bus_if.rd_data_o = rd_data_q;
  assign bus_if.busy_o    = (state_q != IDLE);
  assign bus_if.done_o    = (state_q == DONE);
  assign bus_if.err_o     = err_q;

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Directed and randomized bench for reg_bus_ctrl with a behavioural slot/register model.
module tb_reg_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] latch_rd;
  logic [7:0] latch_wr;
  wire  [7:0] bus_w;

  reg_bus_ctrl_if rb ();

  reg_bus_ctrl dut (
    .clk50M_i   (clk),
    .rst_ni     (rst_n),
    .bus_if     (rb.slave),
    .latch_rd_o (latch_rd),
    .latch_wr_o (latch_wr),
    .bus_io     (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot model: drives the bus when read-strobed, captures when write-strobed.
  logic [7:0] slots [8] = '{default: 8'h00};
  logic [2:0] rd_idx;
  always_comb begin
    rd_idx = 3'd0;
    for (int k = 0; k < 8; k++) if (latch_rd[k]) rd_idx = 3'(k);
  end
  assign bus_w = (|latch_rd) ? slots[rd_idx] : 8'hzz;

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) if (latch_wr[k]) slots[k] <= bus_w;
  end

  typedef struct { logic [7:0] rd; logic [7:0] wr; logic [7:0] bus; } ph_t;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] ref_r [8];
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] oh(input logic [2:0] s);
    logic [7:0] one;
    one = 8'h01;
    return one << s;
  endfunction

  task automatic check_slots();
    for (int k = 0; k < 8; k++)
      if (k != 6) chk($sformatf("slot%0d", k), {24'h0, slots[k]}, {24'h0, ref_r[k]});
    chk("rd_data_hold", {24'h0, rb.rd_data_o}, {24'h0, last_rd});
  endtask

  task automatic do_op(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                       input logic [7:0] imm, input bit extra_req);
    ph_t        ph [$];
    logic [7:0] nref [8];
    bit         illegal;
    illegal = (op == 2'b00 && (src == 3'd6 || dst == 3'd6)) ||
              (op == 2'b01 && dst == 3'd6) || (op == 2'b11 && src == 3'd6);
    nref = ref_r;
    if (!illegal) begin
      case (op)
        2'b00: begin
          ph.push_back('{oh(src), 8'h00, 8'h00});
          ph.push_back('{8'h00, oh(dst), ref_r[src]});
          nref[dst] = ref_r[src];
        end
        2'b01: begin
          ph.push_back('{8'h00, oh(dst), imm});
          nref[dst] = imm;
        end
        2'b11: ph.push_back('{oh(src), 8'h00, 8'h00});
        default: begin
          ph.push_back('{8'h04, 8'h00, 8'h00});
          ph.push_back('{8'h10, 8'h00, 8'h00});
          ph.push_back('{8'h00, 8'h10, ref_r[2]});
          ph.push_back('{8'h00, 8'h04, ref_r[4]});
          ph.push_back('{8'h08, 8'h00, 8'h00});
          ph.push_back('{8'h20, 8'h00, 8'h00});
          ph.push_back('{8'h00, 8'h20, ref_r[3]});
          ph.push_back('{8'h00, 8'h08, ref_r[5]});
          nref[2] = ref_r[4]; nref[4] = ref_r[2];
          nref[3] = ref_r[5]; nref[5] = ref_r[3];
        end
      endcase
    end
    rb.req_i = 1'b1; rb.op_i = op; rb.src_i = src; rb.dst_i = dst; rb.imm_i = imm;
    step();
    rb.req_i = 1'b0;
    rb.imm_i = ~imm;
    if (illegal) begin
      chk("err_pulse", {31'h0, rb.err_o}, 32'd1);
      chk("err_busy", {31'h0, rb.busy_o}, 32'd0);
      chk("err_strobes", {16'h0, latch_rd, latch_wr}, 32'd0);
      step();
      chk("err_once", {31'h0, rb.err_o}, 32'd0);
      chk("err_nodone", {30'h0, rb.done_o, rb.busy_o}, 32'd0);
    end else begin
      foreach (ph[i]) begin
        chk($sformatf("op%0d_ph%0d_rd", op, i), {24'h0, latch_rd}, {24'h0, ph[i].rd});
        chk($sformatf("op%0d_ph%0d_wr", op, i), {24'h0, latch_wr}, {24'h0, ph[i].wr});
        chk($sformatf("op%0d_ph%0d_busy_done", op, i), {30'h0, rb.busy_o, rb.done_o}, 32'd2);
        if (ph[i].wr != 8'h00)
          chk($sformatf("op%0d_ph%0d_bus", op, i), {24'h0, bus_w}, {24'h0, ph[i].bus});
        rb.req_i = extra_req && (i == 0);
        step();
        rb.req_i = 1'b0;
      end
      chk($sformatf("op%0d_done", op), {30'h0, rb.busy_o, rb.done_o}, 32'd3);
      chk($sformatf("op%0d_done_strobes", op), {16'h0, latch_rd, latch_wr}, 32'd0);
      if (op == 2'b11) begin
        last_rd = ref_r[src];
        chk("rdr_data", {24'h0, rb.rd_data_o}, {24'h0, last_rd});
      end
      step();
      chk($sformatf("op%0d_idle", op), {30'h0, rb.busy_o, rb.done_o}, 32'd0);
      ref_r = nref;
    end
    check_slots();
  endtask

  initial begin
    rb.req_i = 1'b0; rb.op_i = 2'b00; rb.src_i = 3'd0; rb.dst_i = 3'd0; rb.imm_i = 8'h00;
    ref_r = '{default: 8'h00};
    last_rd = 8'h00;
    rst_n = 1'b0;
    step(); step();
    chk("rst_strobes", {16'h0, latch_rd, latch_wr}, 32'd0);
    chk("rst_flags", {29'h0, rb.busy_o, rb.done_o, rb.err_o}, 32'd0);
    chk("rst_rd_data", {24'h0, rb.rd_data_o}, 32'd0);
    rst_n = 1'b1;
    step();

    do_op(2'b01, 3'd0, 3'd7, 8'hA5, 1'b0);
    do_op(2'b01, 3'd0, 3'd0, 8'h3C, 1'b0);
    do_op(2'b00, 3'd0, 3'd5, 8'h00, 1'b0);
    do_op(2'b01, 3'd0, 3'd2, 8'h11, 1'b0);
    do_op(2'b01, 3'd0, 3'd3, 8'h22, 1'b0);
    do_op(2'b01, 3'd0, 3'd4, 8'h33, 1'b0);
    do_op(2'b01, 3'd0, 3'd5, 8'h44, 1'b0);
    do_op(2'b10, 3'd0, 3'd0, 8'h00, 1'b0);
    do_op(2'b01, 3'd0, 3'd1, 8'h5A, 1'b0);
    do_op(2'b11, 3'd1, 3'd0, 8'h00, 1'b1);
    do_op(2'b00, 3'd6, 3'd0, 8'h00, 1'b0);
    do_op(2'b01, 3'd0, 3'd6, 8'h77, 1'b0);
    do_op(2'b00, 3'd3, 3'd3, 8'h00, 1'b0);

    // Reset during X2 of an exchange.
    do_op(2'b01, 3'd0, 3'd2, 8'h11, 1'b0);
    do_op(2'b01, 3'd0, 3'd4, 8'h33, 1'b0);
    rb.req_i = 1'b1; rb.op_i = 2'b10;
    step();
    rb.req_i = 1'b0;
    step(); step();
    chk("x2_wr", {24'h0, latch_wr}, 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_strobes", {16'h0, latch_rd, latch_wr}, 32'd0);
    chk("rst_async_busy", {31'h0, rb.busy_o}, 32'd0);
    step();
    rst_n = 1'b1;
    last_rd = 8'h00;
    chk("abort_H", {24'h0, slots[4]}, 32'h33);
    chk("abort_D", {24'h0, slots[2]}, 32'h11);
    step();
    chk("post_rst_busy", {31'h0, rb.busy_o}, 32'd0);
    check_slots();
    do_op(2'b01, 3'd0, 3'd7, 8'hC3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] s, d;
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      s = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      do_op(o, s, d, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
